sw_bounce_gen: RTL

Synthesizable press generator for active-low push-button lines: the transmit end of the key/debounce path.
- Accepts a press command and drives one of NCH switch lines through a mechanical press: bounce-in, hold, bounce-out, release dwell.
- Bounce glitches are LFSR-randomized.
- Used for on-FPGA self-test of the debounce/LED-toggle logic: its sw_n outputs feed the debouncer's switch inputs directly.

---
 rtl/sw_bounce_pkg.sv | 25 ++
 rtl/sw_bounce_lfsr.sv | 27 ++
 rtl/sw_bounce_gen.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_bounce_pkg.sv
// rtl/sw_bounce_pkg.sv - shared types, constants and LFSR step function for the press generator
//
// Contents:
//   sw_state_e        : press sequence state encoding
//   LFSR_POLY         : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   LFSR_SEED_DEFAULT : default nonzero LFSR reset value
//   lfsr_step()       : one right-shifting Galois LFSR step
package sw_bounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BNC_DN = 3'd1,
        ST_HOLD   = 3'd2,
        ST_BNC_UP = 3'd3,
        ST_GAP    = 3'd4
    } sw_state_e;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sw_bounce_lfsr.sv
// rtl/sw_bounce_lfsr.sv - 16-bit Galois LFSR used to randomize bounce glitch lengths
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED
//   en    : advance enable
//   lfsr  : current LFSR state
module sw_bounce_lfsr
    import sw_bounce_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

endmodule

// File: rtl/sw_bounce_gen.sv
// rtl/sw_bounce_gen.sv - mechanical push-button press generator for active-low switch lines
//
// Optional feature macro: SW_BOUNCE_GEN_ABORT_EN adds abort/aborted.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd_valid    : press command valid
//   cmd_ready    : generator idle, command accepted when valid and ready
//   cmd_ch       : target switch line (>= NCH means no line is toggled)
//   cmd_hold     : hold and release-dwell cycles (0 behaves as 1)
//   cmd_bounces  : glitch pairs per edge
//   sw_n         : switch lines, low = pressed
//   busy         : sequence in progress
//   abort        : (optional) cancel the running sequence
//   aborted      : (optional) one-cycle pulse when a sequence was cancelled
//   done         : one-cycle pulse in the final cycle of a completed sequence
module sw_bounce_gen
    import sw_bounce_pkg::*;
#(
    parameter int          NCH       = 3,
    parameter int          HOLD_W    = 20,
    parameter int          GLITCH_W  = 10,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
    localparam int         CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        cmd_bounces,
    output logic [NCH-1:0]    sw_n,
    output logic              busy,
`ifdef SW_BOUNCE_GEN_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              done
);

    localparam int CNT_W = (HOLD_W > GLITCH_W) ? HOLD_W : GLITCH_W;

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_BNC_DN = ST_BNC_DN;
    localparam logic [2:0] S_HOLD   = ST_HOLD;
    localparam logic [2:0] S_BNC_UP = ST_BNC_UP;
    localparam logic [2:0] S_GAP    = ST_GAP;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;        // remaining cycles of the current segment minus one
    logic [3:0]        pairs;      // glitch pairs still to start on this edge
    logic              phase_hi;   // current bounce segment drives the line high
    logic              line_low;
    logic [CH_W-1:0]   ch_q;
    logic              ch_ok;
    logic [HOLD_W-1:0] hold_q;     // effective hold minus one
    logic [3:0]        bounces_q;

    logic [2:0]        nxt_state;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [3:0]        nxt_pairs;
    logic              nxt_phase_hi;
    logic              nxt_low;
    logic              nxt_done;
    logic [NCH-1:0]    nxt_sw_n;
    logic [CH_W-1:0]   sel_ch;
    logic              sel_ok;
`ifdef SW_BOUNCE_GEN_ABORT_EN
    logic              nxt_aborted;
`endif

    logic [15:0]       lfsr;
    logic              lfsr_unused;
    logic [CNT_W-1:0]  glen_m1;
    logic              accept;
    logic              cmd_ch_ok;
    logic [HOLD_W-1:0] cmd_hold_m1;

    sw_bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .lfsr  (lfsr)
    );

    // Only the low GLITCH_W bits set glitch lengths; the rest just feed the shift chain.
    assign lfsr_unused = ^lfsr;
    assign glen_m1     = CNT_W'(lfsr[GLITCH_W-1:0]);

    assign accept      = cmd_valid && cmd_ready;
    assign cmd_ch_ok   = (int'(cmd_ch) < NCH);
    assign cmd_hold_m1 = (cmd_hold == '0) ? '0 : cmd_hold - HOLD_W'(1);

    always_comb begin
        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_pairs    = pairs;
        nxt_phase_hi = phase_hi;
        nxt_low      = line_low;
        sel_ch       = ch_q;
        sel_ok       = ch_ok;
`ifdef SW_BOUNCE_GEN_ABORT_EN
        nxt_aborted  = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                nxt_low = 1'b0;
                if (accept) begin
                    sel_ch = cmd_ch;
                    sel_ok = cmd_ch_ok;
                    if (!cmd_ch_ok) begin
                        // Nothing to drive: single GAP cycle carries the done pulse.
                        nxt_state = S_GAP;
                        nxt_cnt   = '0;
                    end else if (cmd_bounces == 4'd0) begin
                        nxt_state = S_HOLD;
                        nxt_cnt   = CNT_W'(cmd_hold_m1);
                        nxt_low   = 1'b1;
                    end else begin
                        // One-cycle initial contact, then the glitch pairs.
                        nxt_state    = S_BNC_DN;
                        nxt_cnt      = '0;
                        nxt_phase_hi = 1'b0;
                        nxt_pairs    = cmd_bounces;
                        nxt_low      = 1'b1;
                    end
                end
            end

            S_BNC_DN: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_W'(1);
                end else if (phase_hi) begin
                    nxt_phase_hi = 1'b0;
                    nxt_low      = 1'b1;
                    nxt_cnt      = glen_m1;
                end else if (pairs == 4'd0) begin
                    nxt_state = S_HOLD;
                    nxt_cnt   = CNT_W'(hold_q);
                    nxt_low   = 1'b1;
                end else begin
                    nxt_phase_hi = 1'b1;
                    nxt_low      = 1'b0;
                    nxt_cnt      = glen_m1;
                    nxt_pairs    = pairs - 4'd1;
                end
            end

            S_HOLD: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_W'(1);
                end else begin
                    nxt_low = 1'b0;
                    if (bounces_q == 4'd0) begin
                        nxt_state = S_GAP;
                        nxt_cnt   = CNT_W'(hold_q);
                    end else begin
                        // One-cycle initial release, then the glitch pairs.
                        nxt_state    = S_BNC_UP;
                        nxt_cnt      = '0;
                        nxt_phase_hi = 1'b1;
                        nxt_pairs    = bounces_q;
                    end
                end
            end

            S_BNC_UP: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_W'(1);
                end else if (!phase_hi) begin
                    nxt_phase_hi = 1'b1;
                    nxt_low      = 1'b0;
                    nxt_cnt      = glen_m1;
                end else if (pairs == 4'd0) begin
                    nxt_state = S_GAP;
                    nxt_cnt   = CNT_W'(hold_q);
                    nxt_low   = 1'b0;
                end else begin
                    nxt_phase_hi = 1'b0;
                    nxt_low      = 1'b1;
                    nxt_cnt      = glen_m1;
                    nxt_pairs    = pairs - 4'd1;
                end
            end

            S_GAP: begin
                nxt_low = 1'b0;
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_W'(1);
                end else begin
                    nxt_state = S_IDLE;
                end
            end

            default: begin
                nxt_state = S_IDLE;
                nxt_low   = 1'b0;
            end
        endcase

`ifdef SW_BOUNCE_GEN_ABORT_EN
        // Abort wins over everything, including a done that would fire this edge.
        if (abort && (state != S_IDLE)) begin
            nxt_state   = S_IDLE;
            nxt_low     = 1'b0;
            nxt_aborted = 1'b1;
        end
`endif

        // done is registered, so raise it on the edge that enters the last GAP cycle.
        nxt_done = (nxt_state == S_GAP) && (nxt_cnt == '0);

        nxt_sw_n = '1;
        for (int i = 0; i < NCH; i++) begin
            if (nxt_low && sel_ok && (sel_ch == CH_W'(i))) begin
                nxt_sw_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pairs     <= '0;
            phase_hi  <= 1'b0;
            line_low  <= 1'b0;
            ch_q      <= '0;
            ch_ok     <= 1'b0;
            hold_q    <= '0;
            bounces_q <= '0;
            sw_n      <= '1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            pairs     <= nxt_pairs;
            phase_hi  <= nxt_phase_hi;
            line_low  <= nxt_low;
            sw_n      <= nxt_sw_n;
            cmd_ready <= (nxt_state == S_IDLE);
            busy      <= (nxt_state != S_IDLE);
            done      <= nxt_done;
            if (accept) begin
                ch_q      <= cmd_ch;
                ch_ok     <= cmd_ch_ok;
                hold_q    <= cmd_hold_m1;
                bounces_q <= cmd_bounces;
            end
        end
    end

`ifdef SW_BOUNCE_GEN_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted <= 1'b0;
        end else begin
            aborted <= nxt_aborted;
        end
    end
`endif

endmodule
